// File: rtl/pe_feeder.sv
// Feeds a PE column array: loads a 3-row kernel, then streams pixels through a
// staggered shift register with per-row enables, and finally flushes it with zeros.
module pe_feeder #(
  parameter int IMG_ROW    = 13,
  parameter int WEIGHT_ROW = 3,
  parameter int N_COL      = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    go,
  input  logic [2:0]              channel_cfg,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [7:0]              in_data,
  output logic [IMG_ROW-1:0]      start,
  output logic [IMG_ROW*8-1:0]    img,
  output logic [WEIGHT_ROW*8-1:0] weight_top,
  output logic [WEIGHT_ROW*8-1:0] weight_mid,
  output logic [WEIGHT_ROW*8-1:0] weight_bottom,
  output logic [2:0]              channel_packed,
  output logic                    shift_en,
  output logic                    busy,
  output logic                    done
);

  localparam int PIX_W  = $clog2(N_COL + 1);
  localparam int DRN_W  = (IMG_ROW > 2) ? $clog2(IMG_ROW) : 1;
  localparam int LANE_W = (WEIGHT_ROW > 1) ? $clog2(WEIGHT_ROW) : 1;

  typedef enum logic [2:0] {IDLE, LOAD_W, STREAM, DRAIN, FIN} state_t;

  state_t             state_q, state_d;
  logic [1:0]         row_q;
  logic [LANE_W-1:0]  lane_q;
  logic [PIX_W-1:0]   pix_q;
  logic [DRN_W-1:0]   drn_q;

  logic last_w, last_pix, last_drn;
  assign last_w   = (row_q == 2'd2) && (lane_q == LANE_W'(WEIGHT_ROW - 1));
  assign last_pix = (pix_q == PIX_W'(N_COL - 1));
  assign last_drn = (drn_q == DRN_W'(IMG_ROW - 2));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every output and next-state gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers latches.
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    shift_en = 1'b0;
    busy     = (state_q != IDLE);
    done     = 1'b0;
    case (state_q)
      IDLE:   if (go) state_d = LOAD_W;
      LOAD_W: begin
        in_ready = 1'b1;
        if (in_valid && last_w) state_d = STREAM;
      end
      STREAM: begin
        in_ready = 1'b1;
        shift_en = in_valid;
        if (in_valid && last_pix) state_d = DRAIN;
      end
      DRAIN: begin
        shift_en = 1'b1;
        if (last_drn) state_d = FIN;
      end
      FIN: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      start          <= '0;
      img            <= '0;
      weight_top     <= '0;
      weight_mid     <= '0;
      weight_bottom  <= '0;
      channel_packed <= '0;
      row_q          <= '0;
      lane_q         <= '0;
      pix_q          <= '0;
      drn_q          <= '0;
    end else begin
      case (state_q)
        IDLE: if (go) begin
          channel_packed <= channel_cfg;
          start          <= '0;
          img            <= '0;
          row_q          <= '0;
          lane_q         <= '0;
          pix_q          <= '0;
          drn_q          <= '0;
        end
        LOAD_W: if (in_valid) begin
          case (row_q)
            2'd0:    weight_top[{lane_q, 3'b000} +: 8]    <= in_data;
            2'd1:    weight_mid[{lane_q, 3'b000} +: 8]    <= in_data;
            default: weight_bottom[{lane_q, 3'b000} +: 8] <= in_data;
          endcase
          if (lane_q == LANE_W'(WEIGHT_ROW - 1)) begin
            lane_q <= '0;
            row_q  <= row_q + 2'd1;
          end else begin
            lane_q <= lane_q + LANE_W'(1);
          end
        end
        STREAM: if (in_valid) begin
          img   <= {img[IMG_ROW*8-9:0], in_data};
          start <= {start[IMG_ROW-2:0], 1'b1};
          pix_q <= pix_q + PIX_W'(1);
        end
        DRAIN: begin
          img   <= {img[IMG_ROW*8-9:0], 8'h00};
          start <= '1;
          drn_q <= drn_q + DRN_W'(1);
        end
        FIN: start <= '0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_feeder.sv
// Directed bench for pe_feeder: weight load, stream with stall, drain/done,
// go handling around FIN, and asynchronous reset mid-pass.
module tb_pe_feeder;

  logic         clk = 1'b0;
  logic         reset;
  logic         go;
  logic [2:0]   channel_cfg;
  logic         in_valid;
  logic         in_ready;
  logic [7:0]   in_data;
  logic [12:0]  start;
  logic [103:0] img;
  logic [23:0]  weight_top, weight_mid, weight_bottom;
  logic [2:0]   channel_packed;
  logic         shift_en, busy, done;

  int n_checks = 0;
  int n_errors = 0;
  int shift_cnt = 0;
  int done_cnt = 0;

  pe_feeder dut (
    .clk(clk), .reset(reset), .go(go), .channel_cfg(channel_cfg),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .start(start), .img(img), .weight_top(weight_top), .weight_mid(weight_mid),
    .weight_bottom(weight_bottom), .channel_packed(channel_packed),
    .shift_en(shift_en), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (shift_en === 1'b1) shift_cnt++;
    if (done === 1'b1) done_cnt++;
  end

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_start"}, start, 0);
    check({tag, "_img"}, img, 0);
    check({tag, "_wtop"}, weight_top, 0);
    check({tag, "_wmid"}, weight_mid, 0);
    check({tag, "_wbot"}, weight_bottom, 0);
    check({tag, "_packed"}, channel_packed, 0);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_shift_en"}, shift_en, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
  endtask

  initial begin
    reset = 1'b0; go = 1'b0; channel_cfg = 3'b000; in_valid = 1'b0; in_data = 8'h00;
    #3;
    check_all_zero("reset");
    tick();
    reset = 1'b1;
    tick();
    check("idle_in_ready", in_ready, 0);

    // Pass 1: weights 01..09
    go = 1'b1; channel_cfg = 3'b010;
    tick();
    go = 1'b0;
    check("load_busy", busy, 1);
    check("load_in_ready", in_ready, 1);
    check("load_packed", channel_packed, 3'b010);
    for (int i = 1; i <= 9; i++) send(8'(i));
    check("w_top", weight_top, 24'h030201);
    check("w_mid", weight_mid, 24'h060504);
    check("w_bot", weight_bottom, 24'h090807);
    check("stream_shift_cnt0", shift_cnt, 0);

    for (int k = 1; k <= 13; k++) begin
      in_valid = 1'b1; in_data = 8'h01;
      #1;
      check($sformatf("stream_shift_en_%0d", k), shift_en, 1);
      tick();
      check($sformatf("stream_start_%0d", k), start, (13'h1 << k) - 13'h1);
    end
    in_valid = 1'b0;
    check("stream_img_full", img, {13{8'h01}});

    for (int s = 0; s < 4; s++) begin
      #1;
      check($sformatf("stall_shift_en_%0d", s), shift_en, 0);
      check($sformatf("stall_in_ready_%0d", s), in_ready, 1);
      tick();
      check($sformatf("stall_img_%0d", s), img, {13{8'h01}});
      check($sformatf("stall_start_%0d", s), start, 13'h1FFF);
    end

    send(8'hA1);
    send(8'hB2);
    send(8'hC3);
    check("after16_start", start, 13'h1FFF);
    check("after16_img", img, {{10{8'h01}}, 8'hA1, 8'hB2, 8'hC3});
    check("stream_pulses", shift_cnt, 16);

    for (int d = 0; d < 12; d++) begin
      check($sformatf("drain_shift_en_%0d", d), shift_en, 1);
      check($sformatf("drain_in_ready_%0d", d), in_ready, 0);
      check($sformatf("drain_done_%0d", d), done, 0);
      tick();
    end
    check("fin_done", done, 1);
    check("fin_shift_en", shift_en, 0);
    check("fin_busy", busy, 1);
    check("total_pulses", shift_cnt, 28);
    check("fin_img", img, {8'hC3, 96'h0});
    check("w_top_hold", weight_top, 24'h030201);

    // go raised during FIN is ignored; accepted from IDLE on the next cycle
    go = 1'b1; channel_cfg = 3'b101;
    tick();
    check("idle_done", done, 0);
    check("idle_busy", busy, 0);
    check("idle_start", start, 0);
    check("idle_img_kept", img, {8'hC3, 96'h0});
    check("idle_packed_kept", channel_packed, 3'b010);
    check("done_count1", done_cnt, 1);
    tick();
    check("pass2_busy", busy, 1);
    check("pass2_packed", channel_packed, 3'b101);
    check("pass2_img_clr", img, 0);
    channel_cfg = 3'b111;
    for (int i = 1; i <= 9; i++) send(8'h10 + 8'(i));
    check("p2_w_top", weight_top, 24'h131211);
    check("p2_w_mid", weight_mid, 24'h161514);
    check("p2_w_bot", weight_bottom, 24'h191817);
    check("p2_packed_stable", channel_packed, 3'b101);
    for (int k = 1; k <= 5; k++) send(8'h40 + 8'(k));
    check("p2_start5", start, 13'h001F);
    check("p2_img5", img, 104'h4142434445);

    // asynchronous reset mid-stream
    in_valid = 1'b1; go = 1'b0;
    #2 reset = 1'b0;
    #1;
    check_all_zero("async_rst");
    in_valid = 1'b0;
    tick();
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check($sformatf("post_rst_busy_%0d", c), busy, 0);
    end
    check("no_done_on_abort", done_cnt, 1);

    go = 1'b1; channel_cfg = 3'b011;
    tick();
    go = 1'b0;
    check("p3_packed", channel_packed, 3'b011);
    check("p3_in_ready", in_ready, 1);
    for (int i = 1; i <= 9; i++) send(8'h20 + 8'(i));
    check("p3_w_top", weight_top, 24'h232221);
    check("p3_w_mid", weight_mid, 24'h262524);
    check("p3_w_bot", weight_bottom, 24'h292827);
    check("p3_start_clr", start, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
